onehot_encoder_buffered: RTL and testbench

- Registered priority encoder, the inverse of the team's 2x4 decoder.
- Takes an IN_W-bit one-hot/priority vector and returns its index plus status flags.
- A 2-entry output buffer with valid/ready handshakes on both sides, so it can sit between pipelined stages without dropping data under backpressure.
- Round-trips decoder outputs back to the original {in1,in0} code.

---
 rtl/onehot_encoder_buffered.sv | 119 +++++++++++
 tb/tb_onehot_encoder_buffered.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_buffered.sv
// Registered priority encoder with a 2-entry valid/ready output buffer.
// Returns the index of the winning set bit plus zero / not-one-hot flags.
module onehot_encoder_buffered #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 2,
    parameter int PRIO_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi
);

    // state   | meaning
    // S_EMPTY | no result buffered
    // S_ONE   | head holds a result
    // S_FULL  | head and tail both hold results, upstream stalled
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    localparam int ENT_W = OUT_W + 2;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic [ENT_W-1:0]  head_q, head_d;
    logic [ENT_W-1:0]  tail_q, tail_d;
    logic [OUT_W-1:0]  enc_idx;
    logic              enc_zero;
    logic              enc_multi;
    logic [ENT_W-1:0]  enc_ent;
    logic              push;
    logic              pop;

    always_comb begin
        enc_idx = '0;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in_vec[i]) enc_idx = OUT_W'(i);
            end
        end else begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (in_vec[i]) enc_idx = OUT_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign enc_zero  = ~|in_vec;
    assign enc_multi = |(in_vec & (in_vec - IN_W'(1)));
    assign enc_ent   = {enc_multi, enc_zero, enc_idx};

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_ONE;
                    head_d  = enc_ent;
                end
            end
            S_ONE: begin
                if (push && !pop) begin
                    state_d = S_FULL;
                    tail_d  = enc_ent;
                end else if (!push && pop) begin
                    state_d = S_EMPTY;
                end else if (push && pop) begin
                    head_d = enc_ent;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Result fields are gated so an empty buffer always reads zero.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != S_EMPTY);
        out_idx   = '0;
        out_zero  = 1'b0;
        out_multi = 1'b0;
        if (out_valid) begin
            out_idx   = head_q[OUT_W-1:0];
            out_zero  = head_q[OUT_W];
            out_multi = head_q[OUT_W+1];
        end
    end

endmodule

// File: tb/tb_onehot_encoder_buffered.sv
// Scoreboard bench: two encoders (high and low priority) share stimulus;
// expected results are queued on push and checked by a monitor on pop.
module tb_onehot_encoder_buffered;

    typedef struct {
        logic [1:0] hi;
        logic [1:0] lo;
        logic       z;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_vec = 4'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_zero, out_multi;
    logic [1:0] out_idx;
    logic       lo_in_ready, lo_out_valid, lo_out_zero, lo_out_multi;
    logic [1:0] lo_out_idx;

    int   checks = 0;
    int   failures = 0;
    int   occ = 0;
    bit   post_rst = 1'b1;
    exp_t sb[$];

    onehot_encoder_buffered #(.IN_W(4), .OUT_W(2), .PRIO_HIGH(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_zero(out_zero), .out_multi(out_multi));

    onehot_encoder_buffered #(.IN_W(4), .OUT_W(2), .PRIO_HIGH(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lo_in_ready),
        .in_vec(in_vec), .out_valid(lo_out_valid), .out_ready(out_ready),
        .out_idx(lo_out_idx), .out_zero(lo_out_zero), .out_multi(lo_out_multi));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_enc(input logic [3:0] v);
        exp_t e;
        int   n;
        e.hi = 2'd0;
        e.lo = 2'd0;
        n = 0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                if (n == 0) e.hi = 2'(i);
                e.lo = 2'(i);
                n++;
            end
        end
        e.z = (n == 0);
        e.m = (n > 1);
        return e;
    endfunction

    function automatic exp_t mk(input logic [1:0] hi, input logic [1:0] lo, input logic z, input logic m);
        exp_t e;
        e.hi = hi; e.lo = lo; e.z = z; e.m = m;
        return e;
    endfunction

    // Inputs change 2 time units after each rising edge; sampling happens on the falling edge.
    task automatic cyc(input logic v, input logic [3:0] vec, input logic rdy, input exp_t e);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        @(negedge clk);
        if (rst_n && in_valid && in_ready) sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            occ      = 0;
            post_rst = 1'b1;
        end else begin
            chk("out_valid_occ", {31'd0, out_valid}, {31'd0, occ != 0});
            chk("in_ready_occ", {31'd0, in_ready}, {31'd0, (occ != 2) && !post_rst});
            chk("lo_handshake", {30'd0, lo_out_valid, lo_in_ready}, {30'd0, out_valid, in_ready});
            post_rst = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pop_hi", {28'd0, out_multi, out_zero, out_idx}, {28'd0, e.m, e.z, e.hi});
                    chk("pop_lo", {28'd0, lo_out_multi, lo_out_zero, lo_out_idx}, {28'd0, e.m, e.z, e.lo});
                end
            end else if (!out_valid) begin
                chk("idle_zero", {26'd0, out_multi, out_zero, out_idx, lo_out_multi, lo_out_zero, lo_out_idx}, 32'd0);
            end
            occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end
    end

    initial begin
        exp_t tbl[8];
        logic [3:0] vecs[8];
        exp_t nul;
        int guard;
        nul = mk(2'd0, 2'd0, 1'b0, 1'b0);
        vecs[0] = 4'b0001; tbl[0] = mk(2'd0, 2'd0, 1'b0, 1'b0);
        vecs[1] = 4'b0010; tbl[1] = mk(2'd1, 2'd1, 1'b0, 1'b0);
        vecs[2] = 4'b0100; tbl[2] = mk(2'd2, 2'd2, 1'b0, 1'b0);
        vecs[3] = 4'b1000; tbl[3] = mk(2'd3, 2'd3, 1'b0, 1'b0);
        vecs[4] = 4'b1010; tbl[4] = mk(2'd3, 2'd1, 1'b0, 1'b1);
        vecs[5] = 4'b0000; tbl[5] = mk(2'd0, 2'd0, 1'b1, 1'b0);
        vecs[6] = 4'b0110; tbl[6] = mk(2'd2, 2'd1, 1'b0, 1'b1);
        vecs[7] = 4'b1111; tbl[7] = mk(2'd3, 2'd0, 1'b0, 1'b1);

        #1;
        chk("reset_outputs", {28'd0, in_ready, out_valid, out_zero, out_multi}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #2;
        chk("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // Decoder round trip back-to-back, then the flag vectors.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, vecs[i], 1'b1, tbl[i]);
            chk("rt_head", {29'd0, out_valid, out_idx}, {29'd0, 1'b1, tbl[i].hi});
            chk("rt_ready", {31'd0, in_ready}, 32'd1);
        end
        cyc(1'b0, 4'b0000, 1'b1, nul);

        // Backpressure: fill, pop one while the next word waits, then drain.
        cyc(1'b1, 4'b0100, 1'b0, tbl[2]);
        cyc(1'b1, 4'b0010, 1'b0, tbl[1]);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head_hold", {30'd0, out_idx}, 32'd2);
        cyc(1'b1, 4'b1000, 1'b0, tbl[3]);
        chk("bp_head_stable", {30'd0, out_idx}, 32'd2);
        cyc(1'b1, 4'b1000, 1'b1, tbl[3]);
        chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
        chk("bp_next_head", {30'd0, out_idx}, 32'd1);
        cyc(1'b1, 4'b1000, 1'b0, tbl[3]);
        chk("bp_refull", {31'd0, in_ready}, 32'd0);
        cyc(1'b0, 4'b0000, 1'b1, nul);
        cyc(1'b0, 4'b0000, 1'b1, nul);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset with two entries buffered.
        cyc(1'b1, 4'b0001, 1'b0, tbl[0]);
        cyc(1'b1, 4'b1000, 1'b0, tbl[3]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_zero", {24'd0, in_ready, out_valid, out_zero, out_multi, out_idx, lo_out_valid, lo_in_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 4'b0000, 1'b1, nul);
        cyc(1'b0, 4'b0000, 1'b1, nul);
        chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 10000; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 3) != 0), ref_enc(v));
        end

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cyc(1'b0, 4'b0000, 1'b1, nul);
            guard++;
        end
        chk("drain_timeout", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
